// File: rtl/owb_pkg.sv
// Shared types and constants for the output writeback packer slice.
package owb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSHDONE} owb_state_t;

  localparam int OSRAM_ADDR_W = 14;
  localparam int OSRAM_WORDS  = 12288;

  // Next sequential SRAM word address, wrapping to zero at the top of the array.
  function automatic logic [OSRAM_ADDR_W-1:0] wrapInc(input logic [OSRAM_ADDR_W-1:0] addr,
                                                      input int limit);
    if (int'(addr) >= limit - 1) return '0;
    return addr + 1'b1;
  endfunction

endpackage

// File: rtl/owb_fifo.sv
// 32-bit synchronous FIFO that can hand out its two oldest entries and pop one or two per cycle.
module owb_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [31:0]   din,
  input  logic          pop1,
  input  logic          pop2,
  output logic [31:0]   dout0,
  output logic [31:0]   dout1,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rdPtr_q, wrPtr_q, rdNext;
  logic [CW-1:0] count_q;
  logic [1:0]    popN;

  assign popN   = pop2 ? 2'd2 : {1'b0, pop1};
  assign rdNext = rdPtr_q + 1'b1;
  assign dout0  = mem_q[rdPtr_q];
  assign dout1  = mem_q[rdNext];
  assign count  = count_q;
  assign full   = (count_q == CW'(DEPTH));

  always_ff @(posedge clock) begin
    if (push) mem_q[wrPtr_q] <= din;
  end

  // Resetting the pointers is enough to discard whatever the storage still holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      rdPtr_q <= rdPtr_q + AW'(popN);
      count_q <= count_q + CW'(push) - CW'(popN);
    end
  end

endmodule

// File: rtl/output_writeback_packer.sv
// Packs pairs of 32-bit PE results into 64-bit SRAM words and issues paced writes to the output controller.
module output_writeback_packer
  import owb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_LIMIT = OSRAM_WORDS,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OSRAM_ADDR_W-1:0] base_addr,
  input  logic                    in_valid,
  input  logic [31:0]             in_data,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             w_addr,
  output logic [63:0]             w_d,
  output logic                    w_en,
  input  logic                    w_done,
  output logic [OSRAM_ADDR_W-1:0] words_written,
  output logic                    err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  owb_state_t              state_q, state_d;
  logic [OSRAM_ADDR_W-1:0] curAddr_q, curAddr_d, wAddr_q, wAddr_d, words_q, words_d;
  logic [63:0]             wData_q, wData_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    err_q, err_d, flushPend_q, flushPend_d;
  logic                    push, pop1, pop2, full, startOk, baseBad;
  logic [31:0]             dout0, dout1;
  logic [CW-1:0]           count;

  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign startOk  = start && (state_q == IDLE) && !flushPend_q;
  assign baseBad  = (int'(base_addr) >= ADDR_LIMIT);

  owb_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (in_data),
    .pop1  (pop1),
    .pop2  (pop2),
    .dout0 (dout0),
    .dout1 (dout1),
    .count (count),
    .full  (full)
  );

  // An accepted start owns the cycle, so the first word always uses the freshly latched base.
  always_comb begin
    state_d     = state_q;
    curAddr_d   = curAddr_q;
    wAddr_d     = wAddr_q;
    wData_d     = wData_q;
    words_d     = words_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    flushPend_d = flushPend_q | flush;
    pop1        = 1'b0;
    pop2        = 1'b0;
    if (startOk) begin
      curAddr_d = baseBad ? '0 : base_addr;
      words_d   = '0;
      err_d     = baseBad;
    end
    case (state_q)
      IDLE: begin
        if (!startOk) begin
          if (count >= CW'(2)) begin
            pop2    = 1'b1;
            wData_d = {dout1, dout0};
            wAddr_d = curAddr_q;
            state_d = ISSUE;
          end else if (flushPend_q && count == CW'(1)) begin
            pop1    = 1'b1;
            wData_d = {32'h0, dout0};
            wAddr_d = curAddr_q;
            state_d = ISSUE;
          end else if (flushPend_q) begin
            state_d = FLUSHDONE;
          end
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (w_done) begin
          words_d   = words_q + 1'b1;
          curAddr_d = wrapInc(curAddr_q, ADDR_LIMIT);
          state_d   = IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          curAddr_d = wrapInc(curAddr_q, ADDR_LIMIT);
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      FLUSHDONE: begin
        flushPend_d = flush;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (w_done && state_q != WAIT) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      curAddr_q   <= '0;
      wAddr_q     <= '0;
      wData_q     <= '0;
      words_q     <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      flushPend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      curAddr_q   <= curAddr_d;
      wAddr_q     <= wAddr_d;
      wData_q     <= wData_d;
      words_q     <= words_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      flushPend_q <= flushPend_d;
    end
  end

  assign w_en          = (state_q == ISSUE);
  assign done          = (state_q == FLUSHDONE);
  assign busy          = (state_q != IDLE) || (count != '0);
  assign w_addr        = {{(32 - OSRAM_ADDR_W){1'b0}}, wAddr_q};
  assign w_d           = wData_q;
  assign words_written = words_q;
  assign err           = err_q;

endmodule

// File: tb/tb_output_writeback_packer.sv
// Randomized bench for output_writeback_packer; a queue-based model predicts every written word.
module tb_output_writeback_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [13:0] base_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, busy, done, w_en, err, w_done;
  logic [31:0] w_addr;
  logic [63:0] w_d;
  logic [13:0] words_written;

  int          checks = 0;
  int          passes = 0;
  bit          autoAck = 1'b1;
  logic        ackPulse = 1'b0;
  logic        injPulse = 1'b0;
  logic [31:0] refQ[$];
  int          refAddr = 0;
  logic [31:0] capAddr[$];
  logic [63:0] capData[$];
  int          doneCount = 0;
  int          capAtDone = 0;

  assign w_done = ackPulse | injPulse;

  always #5 clock = ~clock;

  output_writeback_packer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .flush         (flush),
    .busy          (busy),
    .done          (done),
    .w_addr        (w_addr),
    .w_d           (w_d),
    .w_en          (w_en),
    .w_done        (w_done),
    .words_written (words_written),
    .err           (err)
  );

  // Behaves as a controller with a one-cycle response delay while autoAck is set.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (done) begin
        doneCount++;
        capAtDone = capData.size();
      end
      if (w_en) begin
        capAddr.push_back(w_addr);
        capData.push_back(w_d);
        if (autoAck) begin
          @(posedge clock);
          #1;
          ackPulse = 1'b1;
          @(posedge clock);
          #1;
          ackPulse = 1'b0;
        end
      end
    end
  end

  // Reference: consecutive results pair up oldest-first; a lone leftover is zero-padded.
  function automatic void modelWord(output logic [31:0] a, output logic [63:0] d);
    a = 32'(refAddr);
    refAddr = (refAddr + 1) % 12288;
    if (refQ.size() >= 2) begin
      d = {refQ[1], refQ[0]};
      void'(refQ.pop_front());
      void'(refQ.pop_front());
    end else if (refQ.size() == 1) begin
      d = {32'h0, refQ.pop_front()};
    end else begin
      d = 'x;
    end
  endfunction

  task automatic clearCaptures();
    capAddr.delete();
    capData.delete();
    doneCount = 0;
    capAtDone = 0;
  endtask

  task automatic startLayer(input int b);
    @(negedge clock);
    start = 1'b1;
    base_addr = 14'(b);
    @(negedge clock);
    start = 1'b0;
    refAddr = (b >= 12288) ? 0 : b;
  endtask

  task automatic doFlush();
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic sendResults(input int n, input bit gaps);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 300) begin
      @(negedge clock);
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = $urandom;
      #1;
      if (in_valid && in_ready) begin
        refQ.push_back(in_data);
        sent++;
      end
      guard++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (sent != n) $display("[TB] FAIL sendResults: accepted %0d required %0d", sent, n);
    else passes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL resetInReady: got %b required 0", in_ready);
    else passes++;
    checks++;
    if ({w_en, done, err, busy} !== 4'b0 || w_addr !== 32'h0 || w_d !== 64'h0 || words_written !== 14'h0)
      $display("[TB] FAIL resetOutputs: w_en=%b done=%b err=%b busy=%b w_addr=%0h w_d=%0h words=%0d required all 0",
               w_en, done, err, busy, w_addr, w_d, words_written);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL releaseInReady: got %b required 1", in_ready);
    else passes++;
  endtask

  task automatic test_basic();
    logic [31:0] ea;
    logic [63:0] ed;
    int guard = 0;
    clearCaptures();
    startLayer(100);
    sendResults(4, 1'b0);
    while (busy && guard < 100) begin @(negedge clock); guard++; end
    checks++;
    if (capData.size() != 2) $display("[TB] FAIL basicWordCount: got %0d required 2", capData.size());
    else passes++;
    foreach (capData[i]) begin
      modelWord(ea, ed);
      checks++;
      if (capAddr[i] !== ea || capData[i] !== ed)
        $display("[TB] FAIL basicWord%0d: got addr %0d data %h required addr %0d data %h", i, capAddr[i], capData[i], ea, ed);
      else passes++;
    end
    checks++;
    if (words_written !== 14'd2 || err !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL basicStatus: words=%0d err=%b busy=%b required 2/0/0", words_written, err, busy);
    else passes++;
  endtask

  task automatic test_flush_odd();
    logic [31:0] ea;
    logic [63:0] ed;
    int guard = 0;
    clearCaptures();
    startLayer(400);
    sendResults(3, 1'b0);
    doFlush();
    while (doneCount == 0 && guard < 100) begin @(negedge clock); guard++; end
    repeat (5) @(negedge clock);
    checks++;
    if (doneCount != 1 || capAtDone != 2)
      $display("[TB] FAIL flushDone: pulses %0d after %0d words, required 1 after 2", doneCount, capAtDone);
    else passes++;
    checks++;
    if (capData.size() != 2) $display("[TB] FAIL flushWordCount: got %0d required 2", capData.size());
    else passes++;
    foreach (capData[i]) begin
      modelWord(ea, ed);
      checks++;
      if (capAddr[i] !== ea || capData[i] !== ed)
        $display("[TB] FAIL flushWord%0d: got addr %0d data %h required addr %0d data %h", i, capAddr[i], capData[i], ea, ed);
      else passes++;
    end
    checks++;
    if (busy !== 1'b0 || words_written !== 14'd2)
      $display("[TB] FAIL flushStatus: busy=%b words=%0d required 0/2", busy, words_written);
    else passes++;
  endtask

  task automatic test_wrap();
    logic [31:0] ea;
    logic [63:0] ed;
    int guard = 0;
    clearCaptures();
    startLayer(12287);
    sendResults(4, 1'b1);
    while (busy && guard < 100) begin @(negedge clock); guard++; end
    checks++;
    if (capData.size() != 2) $display("[TB] FAIL wrapWordCount: got %0d required 2", capData.size());
    else passes++;
    foreach (capData[i]) begin
      modelWord(ea, ed);
      checks++;
      if (capAddr[i] !== ea || capData[i] !== ed)
        $display("[TB] FAIL wrapWord%0d: got addr %0d data %h required addr %0d data %h", i, capAddr[i], capData[i], ea, ed);
      else passes++;
    end
    checks++;
    if (err !== 1'b0) $display("[TB] FAIL wrapErr: got %b required 0", err);
    else passes++;
  endtask

  task automatic test_timeout();
    logic [31:0] ea;
    logic [63:0] ed;
    int accepted = 0;
    int guard = 0;
    clearCaptures();
    autoAck = 1'b0;
    startLayer(200);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data = $urandom;
      #1;
      if (in_ready) begin
        refQ.push_back(in_data);
        accepted++;
      end
    end
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL fullInReady: got %b required 0", in_ready);
    else passes++;
    in_valid = 1'b0;
    checks++;
    if (accepted != 10) $display("[TB] FAIL fullAccepted: got %0d required 10", accepted);
    else passes++;
    while (err !== 1'b1 && guard < 30) begin @(negedge clock); guard++; end
    checks++;
    if (err !== 1'b1 || capData.size() != 1)
      $display("[TB] FAIL timeoutErr: err=%b words issued %0d required 1/1", err, capData.size());
    else passes++;
    autoAck = 1'b1;
    doFlush();
    guard = 0;
    while (doneCount == 0 && guard < 200) begin @(negedge clock); guard++; end
    checks++;
    if (capData.size() != 5 || doneCount != 1)
      $display("[TB] FAIL timeoutDrain: words %0d done %0d required 5/1", capData.size(), doneCount);
    else passes++;
    foreach (capData[i]) begin
      modelWord(ea, ed);
      checks++;
      if (capAddr[i] !== ea || capData[i] !== ed)
        $display("[TB] FAIL timeoutWord%0d: got addr %0d data %h required addr %0d data %h", i, capAddr[i], capData[i], ea, ed);
      else passes++;
    end
    checks++;
    if (words_written !== 14'd4 || err !== 1'b1)
      $display("[TB] FAIL timeoutStatus: words=%0d err=%b required 4/1", words_written, err);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    clearCaptures();
    autoAck = 1'b0;
    startLayer(300);
    sendResults(2, 1'b0);
    while (capData.size() == 0 && guard < 50) begin @(negedge clock); guard++; end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (w_en !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL midReset: w_en=%b busy=%b err=%b in_ready=%b required 0/0/0/0", w_en, busy, err, in_ready);
    else passes++;
    @(negedge clock);
    reset = 1'b0;
    refQ.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL midResetRelease: in_ready=%b required 1", in_ready);
    else passes++;
    repeat (20) @(negedge clock);
    checks++;
    if (capData.size() != 1 || err !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL midResetQuiet: words %0d err=%b busy=%b required 1/0/0", capData.size(), err, busy);
    else passes++;
    autoAck = 1'b1;
  endtask

  task automatic test_err_idle();
    logic [31:0] ea;
    logic [63:0] ed;
    int guard = 0;
    clearCaptures();
    @(negedge clock);
    injPulse = 1'b1;
    @(negedge clock);
    injPulse = 1'b0;
    checks++;
    if (err !== 1'b1) $display("[TB] FAIL strayDoneErr: got %b required 1", err);
    else passes++;
    startLayer(12300);
    checks++;
    if (err !== 1'b1) $display("[TB] FAIL badBaseErr: got %b required 1", err);
    else passes++;
    sendResults(2, 1'b1);
    while (busy && guard < 100) begin @(negedge clock); guard++; end
    checks++;
    if (capData.size() != 1) $display("[TB] FAIL badBaseWords: got %0d required 1", capData.size());
    else passes++;
    foreach (capData[i]) begin
      modelWord(ea, ed);
      checks++;
      if (capAddr[i] !== ea || capData[i] !== ed)
        $display("[TB] FAIL badBaseWord%0d: got addr %0d data %h required addr %0d data %h", i, capAddr[i], capData[i], ea, ed);
      else passes++;
    end
    startLayer(50);
    checks++;
    if (err !== 1'b0 || words_written !== 14'd0)
      $display("[TB] FAIL startClears: err=%b words=%0d required 0/0", err, words_written);
    else passes++;
    clearCaptures();
    doFlush();
    repeat (3) @(negedge clock);
    checks++;
    if (doneCount != 1 || capData.size() != 0)
      $display("[TB] FAIL emptyFlush: done %0d words %0d required 1/0", doneCount, capData.size());
    else passes++;
  endtask

  task automatic test_random();
    logic [31:0] ea;
    logic [63:0] ed;
    for (int iter = 0; iter < 4; iter++) begin
      int n;
      int base;
      int guard = 0;
      clearCaptures();
      base = (iter == 0) ? int'($urandom_range(12283, 12287)) : int'($urandom_range(0, 12287));
      n = int'($urandom_range(1, 9));
      startLayer(base);
      sendResults(n, 1'b1);
      doFlush();
      while (doneCount == 0 && guard < 300) begin @(negedge clock); guard++; end
      repeat (3) @(negedge clock);
      checks++;
      if (capData.size() != (n + 1) / 2 || doneCount != 1)
        $display("[TB] FAIL rand%0dCount: words %0d done %0d required %0d/1", iter, capData.size(), doneCount, (n + 1) / 2);
      else passes++;
      foreach (capData[i]) begin
        modelWord(ea, ed);
        checks++;
        if (capAddr[i] !== ea || capData[i] !== ed)
          $display("[TB] FAIL rand%0dWord%0d: got addr %0d data %h required addr %0d data %h",
                   iter, i, capAddr[i], capData[i], ea, ed);
        else passes++;
      end
      checks++;
      if (int'(words_written) != (n + 1) / 2 || err !== 1'b0 || busy !== 1'b0)
        $display("[TB] FAIL rand%0dStatus: words=%0d err=%b busy=%b required %0d/0/0",
                 iter, words_written, err, busy, (n + 1) / 2);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush_odd();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_err_idle();
    test_random();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
